// File: rtl/jk_bank_ctrl.sv
// ---------------------------------------------------------------------------
// jk_bank_ctrl
//
// Command sequencer for an external bank of WIDTH JK flip-flops that share
// clk and clr with this controller. Host commands (LOAD / CLEAR / UP / DOWN)
// are turned into per-bit J/K drive. UP and DOWN step the bank as a binary
// counter, using the bank's own q outputs as feedback.
//
// Ports
//   clk        in   rising-edge clock; the bank samples j/k on the same edge
//   clr        in   asynchronous active-low reset (shared with the bank)
//   cmd_valid  in   command present
//   cmd_ready  out  controller idle, command accepted when valid & ready
//   cmd_op     in   00 LOAD, 01 CLEAR, 10 UP, 11 DOWN
//   cmd_data   in   LOAD value
//   cmd_steps  in   UP/DOWN step count (0 completes immediately)
//   q_fb       in   bank q outputs
//   j, k       out  registered J/K drive (00 hold, 10 set, 01 reset, 11 toggle)
//   busy       out  command in progress
//   done       out  one-cycle completion pulse
//   tc         out  one-cycle pulse with done when the count wrapped/saturated
//
// Build option
//   JK_SAT_EN  when defined, an UP step at all-ones or a DOWN step at zero
//              issues a hold instead of wrapping, abandons the remaining
//              steps and completes with tc=1. Undefined: modulo wrap, all
//              steps execute.
// ---------------------------------------------------------------------------
module jk_bank_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_CLEAR = 2'b01;

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic             done_q, done_d;
   logic             tc_q, tc_d;

   logic             start_step;
   logic             step_down;
   logic [WIDTH-1:0] up_mask;
   logic [WIDTH-1:0] dn_mask;
   logic [WIDTH-1:0] step_mask;
   logic             step_lim;

   // Toggle masks form a ripple chain: bit i toggles when all lower bits are
   // ones (counting up) or all lower bits are zeros (counting down).
   assign up_mask[0] = 1'b1;
   assign dn_mask[0] = 1'b1;
   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_mask
         assign up_mask[gi] = up_mask[gi-1] &  q_fb[gi-1];
         assign dn_mask[gi] = dn_mask[gi-1] & ~q_fb[gi-1];
      end
   endgenerate

   // The first step is launched straight from IDLE, before op_q is loaded,
   // so direction comes from the live command there.
   assign step_down = (state_q == ST_IDLE) ? cmd_op[0] : op_q[0];
   assign step_mask = step_down ? dn_mask : up_mask;
   assign step_lim  = step_down ? ~(|q_fb) : (&q_fb);

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign j         = j_q;
   assign k         = k_q;
   assign done      = done_q;
   assign tc        = tc_q;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rem_d      = rem_q;
      wrap_d     = wrap_q;
      j_d        = '0;
      k_d        = '0;
      start_step = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               rem_d  = cmd_steps;
               wrap_d = 1'b0;
               case (cmd_op)
                  OP_LOAD: begin
                     j_d     = cmd_data;
                     k_d     = ~cmd_data;
                     state_d = ST_ISSUE;
                  end
                  OP_CLEAR: begin
                     k_d     = '1;
                     state_d = ST_ISSUE;
                  end
                  default: begin
                     if (cmd_steps == '0) begin
                        state_d = ST_DONE;
                     end else begin
                        state_d    = ST_ISSUE;
                        start_step = 1'b1;
                     end
                  end
               endcase
            end
         end

         ST_ISSUE: begin
            if (op_q[1]) begin
`ifdef JK_SAT_EN
               // A saturated step issued a hold; the rest are abandoned.
               state_d = wrap_q ? ST_DONE : ST_WAIT;
`else
               state_d = ST_WAIT;
`endif
            end else begin
               state_d = ST_DONE;
            end
         end

         ST_WAIT: begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               state_d    = ST_ISSUE;
               start_step = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Mask is taken from q_fb on the edge that enters ISSUE; the bank
      // applies it on the following edge.
      if (start_step) begin
`ifdef JK_SAT_EN
         if (step_lim) begin
            wrap_d = 1'b1;
         end else begin
            j_d = step_mask;
            k_d = step_mask;
         end
`else
         j_d = step_mask;
         k_d = step_mask;
         if (step_lim) begin
            wrap_d = 1'b1;
         end
`endif
      end
   end

   // The wrap flag is cleared on every accept, so LOAD/CLEAR and zero-step
   // commands always finish with tc=0.
   assign done_d = (state_d == ST_DONE);
   assign tc_d   = done_d & wrap_d;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         rem_q   <= '0;
         wrap_q  <= 1'b0;
         j_q     <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         wrap_q  <= wrap_d;
         j_q     <= j_d;
         k_q     <= k_d;
         done_q  <= done_d;
         tc_q    <= tc_d;
      end
   end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Testbench for jk_bank_ctrl (default build: modulo wrap). A behavioural JK
// bank closes the q_fb loop; expected results of each command are queued
// when it is driven and compared when done is observed.
module tb_jk_bank_ctrl;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_CLEAR = 2'b01;
   localparam logic [1:0] OP_UP    = 2'b10;
   localparam logic [1:0] OP_DOWN  = 2'b11;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_data = 4'h0;
   logic [7:0] cmd_steps = 8'h0;
   logic [3:0] q_bank;
   logic [3:0] j, k;
   logic       busy, done, tc;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] q;
      logic       tc;
      int         lat;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      logic [3:0] data;
      logic [7:0] steps;
      logic [3:0] q;
      logic       tc;
      int         lat;
   } vec_t;

   exp_t       sb[$];
   logic [3:0] jlog[$];
   logic [3:0] klog[$];
   vec_t       vec[14];

   always #5 clk = ~clk;

   jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .clr       (clr),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_steps (cmd_steps),
      .q_fb      (q_bank),
      .j         (j),
      .k         (k),
      .busy      (busy),
      .done      (done),
      .tc        (tc)
   );

   // External JK bank sharing clk/clr.
   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         q_bank <= 4'h0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            case ({j[b], k[b]})
               2'b10:   q_bank[b] <= 1'b1;
               2'b01:   q_bank[b] <= 1'b0;
               2'b11:   q_bank[b] <= ~q_bank[b];
               default: q_bank[b] <= q_bank[b];
            endcase
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one command, wait for its done pulse, compare against the queued
   // expectation. J/K activity during the command is logged for mask checks.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps,
                          input logic [3:0] eq, input logic etc, input int elat, input string nm);
      exp_t e;
      bit   got;
      bit   fin;
      int   n;
      int   w;
      e.q = eq; e.tc = etc; e.lat = elat;
      sb.push_back(e);
      jlog.delete();
      klog.delete();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps;
      got = 1'b0; w = 0;
      while (!got && w < 50) begin
         got = cmd_ready;
         @(negedge clk);
         w++;
      end
      cmd_valid = 1'b0;
      chk({nm, " accept"}, {31'd0, got}, 32'd1);
      n = 1; fin = 1'b0;
      while (!fin && n <= 600) begin
         if (j != 4'h0 || k != 4'h0) begin
            jlog.push_back(j);
            klog.push_back(k);
         end
         if (done) fin = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk({nm, " done_seen"}, {31'd0, fin}, 32'd1);
      e = sb.pop_front();
      chk({nm, " q"}, {28'd0, q_bank}, {28'd0, e.q});
      chk({nm, " tc"}, {31'd0, tc}, {31'd0, e.tc});
      chk({nm, " latency"}, n, e.lat);
      $display("cmd %s op=%0d data=%0h steps=%0d -> q=%0h tc=%0b lat=%0d", nm, op, data, steps, q_bank, tc, n);
      @(negedge clk);
      chk({nm, " done_pulse_end"}, {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      int rdy_bad;
      int dcount;
      int n;

      vec[0]  = '{OP_LOAD,  4'b1010, 8'd0,   4'b1010, 1'b0, 2};
      vec[1]  = '{OP_CLEAR, 4'b1111, 8'd0,   4'b0000, 1'b0, 2};
      vec[2]  = '{OP_LOAD,  4'b0011, 8'd0,   4'b0011, 1'b0, 2};
      vec[3]  = '{OP_UP,    4'b0000, 8'd3,   4'b0110, 1'b0, 7};
      vec[4]  = '{OP_LOAD,  4'b0001, 8'd0,   4'b0001, 1'b0, 2};
      vec[5]  = '{OP_DOWN,  4'b0000, 8'd2,   4'b1111, 1'b1, 5};
      vec[6]  = '{OP_UP,    4'b0000, 8'd0,   4'b1111, 1'b0, 1};
      vec[7]  = '{OP_LOAD,  4'b1111, 8'd0,   4'b1111, 1'b0, 2};
      vec[8]  = '{OP_UP,    4'b0000, 8'd1,   4'b0000, 1'b1, 3};
      vec[9]  = '{OP_LOAD,  4'b0110, 8'd0,   4'b0110, 1'b0, 2};
      vec[10] = '{OP_DOWN,  4'b0000, 8'd5,   4'b0001, 1'b0, 11};
      vec[11] = '{OP_UP,    4'b0000, 8'd20,  4'b0101, 1'b1, 41};
      vec[12] = '{OP_LOAD,  4'b0000, 8'd0,   4'b0000, 1'b0, 2};
      vec[13] = '{OP_DOWN,  4'b0000, 8'd255, 4'b0001, 1'b1, 511};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset j", {28'd0, j}, 32'd0);
      chk("reset k", {28'd0, k}, 32'd0);
      chk("reset busy/done/tc", {29'd0, busy, done, tc}, 32'd0);
      chk("reset ready", {31'd0, cmd_ready}, 32'd1);
      clr = 1'b1;
      @(negedge clk);
      chk("post-reset ready", {31'd0, cmd_ready}, 32'd1);
      $display("reset released: ready=%0b busy=%0b", cmd_ready, busy);

      for (int i = 0; i < 14; i++) begin
         run_cmd(vec[i].op, vec[i].data, vec[i].steps, vec[i].q, vec[i].tc, vec[i].lat,
                 $sformatf("vec%0d", i));
         if (i == 0) begin
            chk("load jk count", jlog.size(), 32'd1);
            if (jlog.size() == 1) begin
               chk("load j", {28'd0, jlog[0]}, 32'hA);
               chk("load k", {28'd0, klog[0]}, 32'h5);
            end
         end
         if (i == 3) begin
            chk("up3 issue count", jlog.size(), 32'd3);
            if (jlog.size() == 3) begin
               chk("up3 mask0", {24'd0, jlog[0], klog[0]}, 32'h77);
               chk("up3 mask1", {24'd0, jlog[1], klog[1]}, 32'h11);
               chk("up3 mask2", {24'd0, jlog[2], klog[2]}, 32'h33);
            end
         end
         if (i == 6) begin
            chk("up0 no jk activity", jlog.size(), 32'd0);
         end
      end

      // Command held while busy must wait for IDLE.
      run_cmd(OP_LOAD, 4'b0000, 8'd0, 4'b0000, 1'b0, 2, "pre-hold load");
      @(negedge clk);
      chk("hold ready before", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_steps = 8'd2;
      @(negedge clk);
      cmd_op = OP_LOAD; cmd_data = 4'b1001;
      n = 1; rdy_bad = 0;
      while (!done && n < 50) begin
         if (cmd_ready) rdy_bad++;
         @(negedge clk);
         n++;
      end
      chk("hold up latency", n, 32'd5);
      chk("hold up q", {28'd0, q_bank}, 32'h2);
      chk("hold ready while busy", rdy_bad, 32'd0);
      @(negedge clk);
      chk("hold ready at idle", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("held load jk", {24'd0, j, k}, 32'h96);
      @(negedge clk);
      chk("held load done", {31'd0, done}, 32'd1);
      chk("held load q", {28'd0, q_bank}, 32'h9);
      $display("held command: UP2 lat=%0d then LOAD q=%0h", n, q_bank);
      @(negedge clk);

      // clr mid-command.
      run_cmd(OP_LOAD, 4'b0000, 8'd0, 4'b0000, 1'b0, 2, "pre-clr load");
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_UP; cmd_steps = 8'd5;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("clr test issue j", {28'd0, j}, 32'h1);
      @(negedge clk);
      chk("clr test in wait busy", {31'd0, busy}, 32'd1);
      clr = 1'b0;
      #1;
      chk("clr jk", {24'd0, j, k}, 32'd0);
      chk("clr busy/done/tc", {29'd0, busy, done, tc}, 32'd0);
      chk("clr ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      clr = 1'b1;
      dcount = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      chk("no done after clr", dcount, 32'd0);
      $display("clr mid-command: busy=%0b done_count=%0d", busy, dcount);
      run_cmd(OP_LOAD, 4'b0101, 8'd0, 4'b0101, 1'b0, 2, "post-clr load");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
